nn_mac_stage: RTL and testbench

NN_MAC_STAGE -- requirements
Module: nn_mac_stage

---
 rtl/nn_mac_stage.sv | 148 ++++++++++++++
 tb/tb_nn_mac_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mac_stage.sv
// nn_mac_stage: one neuron's multiply-accumulate stage feeding a sigmoid stage.
// Accepts a vector of (x, w) beats and adds a bias taken from the first beat.
// The sum saturates to the ACC_W signed range. One pre-activation result is
// presented per vector through a valid/ready handshake.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input beat valid
//   in_ready   stage accepts a beat this cycle (low in DONE and during reset)
//   in_x       signed activation
//   in_w       signed weight paired with in_x
//   in_bias    signed bias, used only on the first beat of a vector
//   in_last    final beat of a vector
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_h      signed pre-activation sum (0 when out_valid=0)
//   out_sat    saturation occurred somewhere in the vector (0 when out_valid=0)
//   out_err    vector length differed from N_INPUTS (0 when out_valid=0)
module nn_mac_stage #(
  parameter int N_INPUTS = 2,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_w,
  input  logic signed [DATA_W-1:0] in_bias,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_h,
  output logic                     out_sat,
  output logic                     out_err
);

  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam int SUM_W  = ACC_W + 2;
  localparam int PROD_W = 2 * DATA_W;

  // The saturation limits are built as bit patterns so that no 32-bit integer overflow occurs for wide ACC_W.
  localparam logic signed [SUM_W-1:0] ACC_MAX = {{3{1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {{3{1'b1}}, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                    state;
  state_t                    state_next;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          count;
  logic                      sat;
  logic                      err;

  logic                      accept;
  logic                      terminate;
  logic [CNT_W-1:0]          count_next;
  logic signed [PROD_W-1:0]  prod;
  logic signed [SUM_W-1:0]   base;
  logic signed [SUM_W-1:0]   sum;
  logic signed [ACC_W-1:0]   sum_sat;
  logic                      sum_ovf;

  // ---------------------------------------------------------------------------
  // Datapath: full-precision product, two guard bits on the add, then clamp.
  // ---------------------------------------------------------------------------
  assign prod = in_x * in_w;

  // The bias replaces the accumulator on the first beat of a vector.
  assign base = (state == IDLE) ? {{(SUM_W-DATA_W){in_bias[DATA_W-1]}}, in_bias}
                                : {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign sum  = base + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};

  // NOTE: every output of a combinational block gets a default first; otherwise a path that does not assign it infers a latch.
  always_comb begin
    sum_sat = sum[ACC_W-1:0];
    sum_ovf = 1'b0;
    if (sum > ACC_MAX) begin
      sum_sat = ACC_MAX[ACC_W-1:0];
      sum_ovf = 1'b1;
    end else if (sum < ACC_MIN) begin
      sum_sat = ACC_MIN[ACC_W-1:0];
      sum_ovf = 1'b1;
    end
  end

  assign accept     = in_valid && in_ready;
  assign count_next = (state == IDLE) ? CNT_W'(1) : count + 1'b1;
  // A vector ends on in_last or on the N_INPUTS-th beat, whichever comes first.
  assign terminate  = accept && (in_last || (count_next == CNT_W'(N_INPUTS)));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = terminate ? DONE : ACCUM;
      ACCUM:   if (terminate) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. Result fields are forced to zero whenever no result is presented.
  always_comb begin
    in_ready  = rst_n && (state != DONE);
    out_valid = (state == DONE);
    out_h     = out_valid ? acc : '0;
    out_sat   = out_valid && sat;
    out_err   = out_valid && err;
  end

  // ---------------------------------------------------------------------------
  // Accumulator, beat counter and sticky flags
  // ---------------------------------------------------------------------------
  // NOTE: reset is synchronous; these registers clear only on a rising edge with rst_n low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
      err   <= 1'b0;
    end else if (state == DONE) begin
      if (out_ready) begin
        acc   <= '0;
        count <= '0;
        sat   <= 1'b0;
        err   <= 1'b0;
      end
    end else if (accept) begin
      acc   <= sum_sat;
      count <= count_next;
      sat   <= sat | sum_ovf;
      if (terminate) err <= (count_next != CNT_W'(N_INPUTS)) || !in_last;
    end
  end

endmodule

// File: tb/tb_nn_mac_stage.sv
// tb_nn_mac_stage: self-checking bench for nn_mac_stage.
// The bench uses one instance with N_INPUTS=2 for most scenarios and one
// instance with N_INPUTS=4 for the saturation case. Expected results come from
// constants or from a beat-list model that uses plain integer arithmetic.
module tb_nn_mac_stage;

  localparam int DW = 8;
  localparam int AW = 16;

  typedef struct {
    int x;
    int w;
    int b;
    bit last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  // N_INPUTS = 2 instance
  logic                 in_valid, in_ready, in_last, out_valid, out_ready, out_sat, out_err;
  logic signed [DW-1:0] in_x, in_w, in_bias;
  logic signed [AW-1:0] out_h;

  // N_INPUTS = 4 instance
  logic                 in_valid_4, in_ready_4, in_last_4, out_valid_4, out_ready_4, out_sat_4, out_err_4;
  logic signed [DW-1:0] in_x_4, in_w_4, in_bias_4;
  logic signed [AW-1:0] out_h_4;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  nn_mac_stage #(.N_INPUTS(2), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_bias(in_bias), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_h(out_h),
    .out_sat(out_sat), .out_err(out_err)
  );

  nn_mac_stage #(.N_INPUTS(4), .DATA_W(DW), .ACC_W(AW)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_4), .in_ready(in_ready_4),
    .in_x(in_x_4), .in_w(in_w_4), .in_bias(in_bias_4), .in_last(in_last_4),
    .out_valid(out_valid_4), .out_ready(out_ready_4), .out_h(out_h_4),
    .out_sat(out_sat_4), .out_err(out_err_4)
  );

  // Reference model: walk the beat list, add bias once, clamp each partial sum,
  // and stop at the first in_last or at beat n.
  function automatic void model(input beat_t v[$], input int n,
                                output int h, output bit sat, output bit err);
    longint acc;
    longint hi;
    longint lo;
    int     used;
    hi  = (longint'(1) <<< (AW - 1)) - 1;
    lo  = -(longint'(1) <<< (AW - 1));
    acc = 0;
    sat = 0;
    err = 0;
    for (int i = 0; i < v.size(); i++) begin
      acc = ((i == 0) ? longint'(v[i].b) : acc) + longint'(v[i].x) * longint'(v[i].w);
      if (acc > hi) begin acc = hi; sat = 1; end
      if (acc < lo) begin acc = lo; sat = 1; end
      used = i + 1;
      if (v[i].last || used == n) begin
        err = (used != n) || !v[i].last;
        break;
      end
    end
    h = int'(acc);
  endfunction

  function automatic beat_t mk(input int x, input int w, input int b, input bit last);
    beat_t t;
    t.x = x; t.w = w; t.b = b; t.last = last;
    return t;
  endfunction

  // Present one beat on the N=2 instance, wait (bounded) for in_ready, and
  // return one cycle after the accepting edge.
  task automatic send_beat(input beat_t bt);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_x     = DW'(bt.x);
    in_w     = DW'(bt.w);
    in_bias  = DW'(bt.b);
    in_last  = bt.last;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      tests_run++;
      fails++;
      $display("FAIL send_timeout: in_ready got %0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Sample the result on the N=2 instance, then complete the handshake.
  task automatic collect(output bit v, output int h, output bit s, output bit e, output bit rdy);
    v   = out_valid;
    h   = int'(out_h);
    s   = out_sat;
    e   = out_err;
    rdy = in_ready;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1; in_x = 8'sd1; in_w = 8'sd1; in_bias = 8'sd0; in_last = 1'b1;
    out_ready = 1'b0;
    in_valid_4 = 1'b0; in_x_4 = '0; in_w_4 = '0; in_bias_4 = '0; in_last_4 = 1'b0;
    out_ready_4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %0b required 0", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    tests_run++; if (out_h !== '0) begin fails++; $display("FAIL reset_out_h: got %0d required 0", out_h); end
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tests_run++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready); end
    tests_run++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid: got %0b required 0", out_valid); end
  endtask

  task automatic test_and;
    bit v, s, e, r; int h;
    send_beat(mk(1, 20, -30, 0));
    send_beat(mk(1, 20, 5, 1));      // bias on a later beat must be ignored
    collect(v, h, s, e, r);
    tests_run++; if (v !== 1'b1) begin fails++; $display("FAIL and_latency: out_valid got %0b required 1", v); end
    tests_run++; if (h != 10) begin fails++; $display("FAIL and_out_h: got %0d required 10", h); end
    tests_run++; if (s !== 1'b0) begin fails++; $display("FAIL and_sat: got %0b required 0", s); end
    tests_run++; if (e !== 1'b0) begin fails++; $display("FAIL and_err: got %0b required 0", e); end
  endtask

  task automatic test_back_to_back;
    int xa[4]  = '{0, 0, 1, 1};
    int xb[4]  = '{0, 1, 0, 1};
    int exp[4] = '{-30, -10, -10, 10};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(mk(xa[i], 20, -30, 0));
      send_beat(mk(xb[i], 20, -30, 1));
      tests_run++; if (out_valid !== 1'b1 || out_h !== AW'(exp[i])) begin
        fails++; $display("FAIL b2b_result[%0d]: got valid=%0b h=%0d required valid=1 h=%0d", i, out_valid, out_h, exp[i]);
      end
      tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_bubble[%0d]: in_ready got %0b required 0", i, in_ready); end
      @(posedge clk); #1;
      tests_run++; if (out_valid !== 1'b0 || out_h !== '0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL b2b_idle[%0d]: got valid=%0b h=%0d rdy=%0b required 0 0 1", i, out_valid, out_h, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_length_err;
    bit v, s, e, r; int h;
    // Early in_last: a one-beat vector.
    send_beat(mk(1, 20, -30, 1));
    collect(v, h, s, e, r);
    tests_run++; if (v !== 1'b1 || h != -10) begin fails++; $display("FAIL short_out_h: got valid=%0b h=%0d required 1 -10", v, h); end
    tests_run++; if (e !== 1'b1) begin fails++; $display("FAIL short_err: got %0b required 1", e); end
    // Three beats without in_last: the vector closes after beat two.
    send_beat(mk(1, 20, -30, 0));
    send_beat(mk(1, 20, 0, 0));
    tests_run++; if (out_valid !== 1'b1 || out_h !== 16'sd10) begin
      fails++; $display("FAIL count_term: got valid=%0b h=%0d required 1 10", out_valid, out_h);
    end
    collect(v, h, s, e, r);
    send_beat(mk(1, 20, -30, 1));    // third beat starts a fresh vector
    collect(v, h, s, e, r);
    tests_run++; if (v !== 1'b1 || h != -10) begin fails++; $display("FAIL third_beat_new_vec: got valid=%0b h=%0d required 1 -10", v, h); end
  endtask

  task automatic test_stall;
    bit v, s, e, r; int h;
    send_beat(mk(1, 20, -30, 0));
    send_beat(mk(0, 20, -30, 1));
    // Offer the next beat while the result is held.
    in_valid = 1'b1; in_x = 8'sd1; in_w = 8'sd20; in_bias = -8'sd30; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (out_valid !== 1'b1 || out_h !== -16'sd10 || in_ready !== 1'b0) begin
        fails++; $display("FAIL stall_hold[%0d]: got valid=%0b h=%0d rdy=%0b required 1 -10 0", i, out_valid, out_h, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests_run++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL stall_release: got rdy=%0b valid=%0b required 1 0", in_ready, out_valid);
    end
    send_beat(mk(1, 20, -30, 0));    // the held beat, accepted now
    send_beat(mk(1, 20, -30, 1));
    collect(v, h, s, e, r);
    tests_run++; if (v !== 1'b1 || h != 10) begin fails++; $display("FAIL stall_next_vec: got valid=%0b h=%0d required 1 10", v, h); end
  endtask

  task automatic test_mid_reset;
    bit v, s, e, r; int h;
    bit seen;
    send_beat(mk(1, 20, -30, 0));
    rst_n = 1'b0;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    tests_run++; if (seen !== 1'b0) begin fails++; $display("FAIL rst_discard: out_valid seen %0b required 0", seen); end
    send_beat(mk(1, 20, -30, 0));
    send_beat(mk(1, 20, -30, 1));
    collect(v, h, s, e, r);
    tests_run++; if (v !== 1'b1 || h != 10 || e !== 1'b0) begin
      fails++; $display("FAIL rst_next_vec: got valid=%0b h=%0d err=%0b required 1 10 0", v, h, e);
    end
  endtask

  task automatic test_random;
    beat_t q[$];
    int    len, exp_h, h;
    bit    exp_s, exp_e, v, s, e, r;
    for (int n = 0; n < 40; n++) begin
      q.delete();
      len = int'($urandom_range(1, 2));
      for (int i = 0; i < len; i++) begin
        if (n % 8 == 0) q.push_back(mk(-128, -128, 127, i == len - 1));  // pushes toward saturation
        else q.push_back(mk(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                            int'($urandom_range(0, 255)) - 128, i == len - 1));
      end
      model(q, 2, exp_h, exp_s, exp_e);
      foreach (q[i]) send_beat(q[i]);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
      collect(v, h, s, e, r);
      tests_run++; if (v !== 1'b1 || h != exp_h || s !== exp_s || e !== exp_e) begin
        fails++;
        $display("FAIL random[%0d]: got valid=%0b h=%0d sat=%0b err=%0b required 1 %0d %0b %0b",
                 n, v, h, s, e, exp_h, exp_s, exp_e);
      end
    end
  endtask

  task automatic test_sat_n4;
    beat_t q[$];
    int    exp_h;
    bit    exp_s, exp_e;
    for (int k = 0; k < 2; k++) begin
      q.delete();
      if (k == 0) for (int i = 0; i < 4; i++) q.push_back(mk(127, 127, 127, i == 3));
      else begin
        q.push_back(mk(-100, 90, -7, 0));
        q.push_back(mk(55, -3, 12, 1));                 // early in_last on a 4-input neuron
      end
      model(q, 4, exp_h, exp_s, exp_e);
      foreach (q[i]) begin
        in_valid_4 = 1'b1;
        in_x_4 = DW'(q[i].x); in_w_4 = DW'(q[i].w); in_bias_4 = DW'(q[i].b); in_last_4 = q[i].last;
        tests_run++; if (in_ready_4 !== 1'b1) begin fails++; $display("FAIL n4_in_ready[%0d]: got %0b required 1", i, in_ready_4); end
        @(posedge clk); #1;
      end
      in_valid_4 = 1'b0;
      tests_run++; if (out_valid_4 !== 1'b1 || out_h_4 !== AW'(exp_h) || out_sat_4 !== exp_s || out_err_4 !== exp_e) begin
        fails++;
        $display("FAIL n4_result[%0d]: got valid=%0b h=%0d sat=%0b err=%0b required 1 %0d %0b %0b",
                 k, out_valid_4, out_h_4, out_sat_4, out_err_4, exp_h, exp_s, exp_e);
      end
      out_ready_4 = 1'b1;
      @(posedge clk); #1;
      out_ready_4 = 1'b0;
    end
    tests_run++; if (exp_h == 32767) begin fails++; $display("FAIL n4_model_last: got %0d required not 32767", exp_h); end
  endtask

  initial begin
    test_reset();
    test_and();
    test_back_to_back();
    test_length_err();
    test_stall();
    test_mid_reset();
    test_random();
    test_sat_n4();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
